led_div_ctrl: RTL and testbench

- Upstream control stage for the LED counter (`led_cnt`). It turns two raw pushbuttons (up/down) into a registered 5-bit divisor plus a single-cycle write strobe.
- Its outputs drive `led_cnt` `div_i`/`wren_i` directly, replacing the hard-wired `5'hB`/`1'b0` tie-offs.
- Each button is synchronised and debounced, and only its press edge is acted on.

---
 rtl/led_pkg.sv | 15 +
 rtl/led_debounce.sv | 57 +++++
 rtl/led_div_ctrl.sv | 92 +++++++++
 tb/tb_led_div_ctrl.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// Shared types and constants for the LED counter and its divisor control stage.
package led_pkg;

  localparam int DIV_W = 5;

  typedef logic [DIV_W-1:0] div_t;

  localparam div_t DIV_DEFAULT = 5'hB;

  // Width of a counter that must reach n-1; n is at least 2.
  function automatic int cnt_width(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/led_debounce.sv
// Pushbutton conditioner: 2-FF synchroniser, stability counter and a one-cycle
// pulse on each accepted press (debounced 0->1 transition).
module led_debounce
  import led_pkg::*;
#(
  parameter int DEB_CYCLES = 1000000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_i,
  output logic rise_o
);

  localparam int CNT_W = cnt_width(DEB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic [1:0]       sync_q;
  logic             btn_s;
  logic             deb_q, deb_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rise_q, rise_d;

  assign btn_s = sync_q[1];

  // The counter only runs while the synchronised level disagrees with the
  // accepted level; any agreement restarts the stability window.
  always_comb begin
    deb_d  = deb_q;
    cnt_d  = '0;
    rise_d = 1'b0;
    if (btn_s != deb_q) begin
      if (cnt_q == CNT_LAST) begin
        deb_d  = btn_s;
        rise_d = btn_s;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= 2'b00;
      deb_q  <= 1'b0;
      cnt_q  <= '0;
      rise_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], btn_i};
      deb_q  <= deb_d;
      cnt_q  <= cnt_d;
      rise_q <= rise_d;
    end
  end

  assign rise_o = rise_q;

endmodule

// File: rtl/led_div_ctrl.sv
// Divisor control for led_cnt: two debounced buttons step a registered divisor.
// Define LED_DIV_WRAP_EN to wrap at DIV_MIN/DIV_MAX instead of saturating.
module led_div_ctrl
  import led_pkg::*;
#(
  parameter int   DEB_CYCLES = 1000000,
  parameter div_t DIV_RST    = DIV_DEFAULT,
  parameter div_t DIV_MIN    = 5'h01,
  parameter div_t DIV_MAX    = 5'h1F
) (
  input  logic clk100,
  input  logic rst,
  input  logic btn_up_i,
  input  logic btn_dn_i,
  output div_t div_o,
  output logic wren_o
);

  logic up_ev, dn_ev;
  div_t div_q, div_d;
  logic wren_q, wren_d;

  led_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_up (
    .clk_i  (clk100),
    .rst_ni (rst),
    .btn_i  (btn_up_i),
    .rise_o (up_ev)
  );

  led_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_dn (
    .clk_i  (clk100),
    .rst_ni (rst),
    .btn_i  (btn_dn_i),
    .rise_o (dn_ev)
  );

  // wren_o is a valid-only strobe with no backpressure: it is high for exactly
  // the one cycle in which div_o holds a newly loaded value.
  always_comb begin
    div_d  = div_q;
    wren_d = 1'b0;
    case ({up_ev, dn_ev})
      2'b10: begin
        if (div_q < DIV_MAX) begin
          div_d  = div_q + 1'b1;
          wren_d = 1'b1;
        end else begin
`ifdef LED_DIV_WRAP_EN
          div_d  = DIV_MIN;
          wren_d = 1'b1;
`else
          div_d  = div_q;
          wren_d = 1'b0;
`endif
        end
      end
      2'b01: begin
        if (div_q > DIV_MIN) begin
          div_d  = div_q - 1'b1;
          wren_d = 1'b1;
        end else begin
`ifdef LED_DIV_WRAP_EN
          div_d  = DIV_MAX;
          wren_d = 1'b1;
`else
          div_d  = div_q;
          wren_d = 1'b0;
`endif
        end
      end
      default: begin
        // No event, or both buttons at once: treated as an ambiguous request.
        div_d  = div_q;
        wren_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk100 or negedge rst) begin
    if (!rst) begin
      div_q  <= DIV_RST;
      wren_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      wren_q <= wren_d;
    end
  end

  assign div_o  = div_q;
  assign wren_o = wren_q;

endmodule

// File: tb/tb_led_div_ctrl.sv
// Directed bench for led_div_ctrl with DEB_CYCLES=4 (press-to-strobe latency 7).
module tb_led_div_ctrl;

  logic       clk100;
  logic       rst;
  logic       btn_up_i;
  logic       btn_dn_i;
  logic [4:0] div_o;
  logic       wren_o;

  int n_tests = 0;
  int n_fail  = 0;

  logic       prev_wren;
  logic [4:0] prev_div;

  typedef struct {
    string      name;
    logic       up;
    logic       dn;
    logic [4:0] exp_div;
    int         exp_pulses;
  } vec_t;

  vec_t vecs[5];

  led_div_ctrl #(
    .DEB_CYCLES (4),
    .DIV_RST    (5'h0B),
    .DIV_MIN    (5'h01),
    .DIV_MAX    (5'h1F)
  ) dut (
    .clk100   (clk100),
    .rst      (rst),
    .btn_up_i (btn_up_i),
    .btn_dn_i (btn_dn_i),
    .div_o    (div_o),
    .wren_o   (wren_o)
  );

  // ---------------- clock / reset ----------------
  initial clk100 = 1'b0;
  always #5 clk100 = ~clk100;

  // ---------------- driver / checker tasks ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock; samples 1 time unit after the edge and checks the strobe invariants.
  task automatic step();
    @(posedge clk100);
    #1;
    if (rst) begin
      check("wren_back_to_back", {31'b0, wren_o & prev_wren}, 32'd0);
      check("wren_iff_change", {31'b0, wren_o}, {31'b0, (div_o != prev_div)});
    end
    prev_wren = wren_o;
    prev_div  = div_o;
  endtask

  task automatic press(input logic up, input logic dn, output int pulses);
    pulses   = 0;
    btn_up_i = up;
    btn_dn_i = dn;
    repeat (12) begin
      step();
      if (wren_o) pulses++;
    end
    btn_up_i = 1'b0;
    btn_dn_i = 1'b0;
    repeat (10) begin
      step();
      if (wren_o) pulses++;
    end
  endtask

  // Clean up-press: strobe must appear exactly at edge 7, then never again.
  task automatic latency_up(input string tag, input logic [4:0] exp_div);
    int extra;
    btn_up_i = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      step();
      if (e < 7) check({tag, "_early_wren"}, {31'b0, wren_o}, 32'd0);
    end
    check({tag, "_wren_edge7"}, {31'b0, wren_o}, 32'd1);
    check({tag, "_div"}, {27'b0, div_o}, {27'b0, exp_div});
    extra = 0;
    repeat (13) begin
      step();
      if (wren_o) extra++;
    end
    btn_up_i = 1'b0;
    repeat (10) begin
      step();
      if (wren_o) extra++;
    end
    check({tag, "_no_repeat"}, extra, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int         pulses;
    logic [4:0] cur;
    logic [4:0] exp;

`ifdef LED_DIV_WRAP_EN
    vecs[0] = '{"over_max", 1'b1, 1'b0, 5'h01, 1};
    vecs[1] = '{"under_min", 1'b0, 1'b1, 5'h1F, 1};
    vecs[2] = '{"both", 1'b1, 1'b1, 5'h1F, 0};
    vecs[3] = '{"dn_step", 1'b0, 1'b1, 5'h1E, 1};
    vecs[4] = '{"up_step", 1'b1, 1'b0, 5'h1F, 1};
`else
    vecs[0] = '{"over_max", 1'b1, 1'b0, 5'h1F, 0};
    vecs[1] = '{"dn_from_max", 1'b0, 1'b1, 5'h1E, 1};
    vecs[2] = '{"both", 1'b1, 1'b1, 5'h1E, 0};
    vecs[3] = '{"dn_step", 1'b0, 1'b1, 5'h1D, 1};
    vecs[4] = '{"up_step", 1'b1, 1'b0, 5'h1E, 1};
`endif

    btn_up_i  = 1'b0;
    btn_dn_i  = 1'b0;
    rst       = 1'b0;
    prev_wren = 1'b0;
    prev_div  = 5'h0B;

    // Reset state and quiet idle.
    repeat (3) step();
    check("reset_div", {27'b0, div_o}, 32'h0B);
    check("reset_wren", {31'b0, wren_o}, 32'd0);
    rst    = 1'b1;
    pulses = 0;
    repeat (100) begin
      step();
      if (wren_o) pulses++;
    end
    check("idle_pulses", pulses, 0);
    check("idle_div", {27'b0, div_o}, 32'h0B);

    // Latency and no auto-repeat.
    latency_up("up_latency", 5'h0C);

    // Down-button bounce, then a stable press.
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      btn_dn_i = ~i[0];
      repeat (2) begin
        step();
        if (wren_o) pulses++;
      end
    end
    btn_dn_i = 1'b1;
    repeat (2) begin
      step();
      if (wren_o) pulses++;
    end
    check("bounce_no_event", pulses, 0);
    check("bounce_div_kept", {27'b0, div_o}, 32'h0C);
    repeat (12) begin
      step();
      if (wren_o) pulses++;
    end
    btn_dn_i = 1'b0;
    repeat (10) step();
    check("bounce_then_stable_pulses", pulses, 1);
    check("bounce_then_stable_div", {27'b0, div_o}, 32'h0B);

    // Climb from 0x0B to DIV_MAX one press at a time.
    cur = 5'h0B;
    for (int i = 0; i < 20; i++) begin
      press(1'b1, 1'b0, pulses);
      exp = (cur < 5'h1F) ? cur + 5'd1 : cur;
      check("climb_div", {27'b0, div_o}, {27'b0, exp});
      check("climb_pulses", pulses, (cur < 5'h1F) ? 1 : 0);
      cur = exp;
    end
    check("at_max", {27'b0, div_o}, 32'h1F);

    // Boundary and simultaneous-press vectors.
    for (int v = 0; v < 5; v++) begin
      press(vecs[v].up, vecs[v].dn, pulses);
      check({vecs[v].name, "_div"}, {27'b0, div_o}, {27'b0, vecs[v].exp_div});
      check({vecs[v].name, "_pulses"}, pulses, vecs[v].exp_pulses);
    end

    // Descend to DIV_MIN, then one press past it.
    cur = div_o;
    for (int i = 0; i < 30; i++) begin
      press(1'b0, 1'b1, pulses);
      exp = (cur > 5'h01) ? cur - 5'd1 : cur;
      check("descend_div", {27'b0, div_o}, {27'b0, exp});
      check("descend_pulses", pulses, (cur > 5'h01) ? 1 : 0);
      cur = exp;
    end
    check("at_min", {27'b0, div_o}, 32'h01);
    press(1'b0, 1'b1, pulses);
`ifdef LED_DIV_WRAP_EN
    check("under_min_div", {27'b0, div_o}, 32'h1F);
    check("under_min_pulses", pulses, 1);
`else
    check("under_min_div", {27'b0, div_o}, 32'h01);
    check("under_min_pulses", pulses, 0);
`endif

    // Reset two cycles into a held press aborts it.
    btn_up_i = 1'b1;
    step();
    step();
    rst = 1'b0;
    #1;
    check("midreset_div", {27'b0, div_o}, 32'h0B);
    check("midreset_wren", {31'b0, wren_o}, 32'd0);
    prev_div  = 5'h0B;
    prev_wren = 1'b0;
    btn_up_i  = 1'b0;
    repeat (3) step();
    check("midreset_hold_div", {27'b0, div_o}, 32'h0B);
    rst    = 1'b1;
    pulses = 0;
    repeat (10) begin
      step();
      if (wren_o) pulses++;
    end
    check("midreset_no_strobe", pulses, 0);
    latency_up("repress_latency", 5'h0C);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
